// File: rtl/usb_rx_txn_ctrl.sv
// Receive-transaction controller: sequences the token, data and handshake packets of an
// OUT transaction and streams the data payload downstream, holding back the trailing CRC16.
module usb_rx_txn_ctrl #(
  parameter int         MAX_DATA_BYTES = 8,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] SYNC_BYTE      = 8'h80,
  parameter logic [7:0] TOKEN_PID      = 8'h96,
  parameter logic [7:0] DATA0_PID      = 8'h3C,
  parameter logic [7:0] DATA1_PID      = 8'hB4,
  parameter logic [7:0] ACK_PID        = 8'h2D,
  localparam int        CW             = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          eop,
  input  logic          crc5_ok,
  input  logic          crc16_ok,
  input  logic          clear_toggle,
  output logic          wr_en,
  output logic [7:0]    wr_data,
  output logic [CW-1:0] byte_count,
  output logic          rcv_data_ready,
  output logic          rcv_error,
  output logic [2:0]    error_code,
  output logic          data_toggle,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DATA_BYTES);

  localparam logic [2:0] ERR_SYNC    = 3'd1;
  localparam logic [2:0] ERR_PID     = 3'd2;
  localparam logic [2:0] ERR_TOGGLE  = 3'd3;
  localparam logic [2:0] ERR_CRC     = 3'd4;
  localparam logic [2:0] ERR_FRAME   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_TOK_PID, S_TOK_BODY, S_TOK_EOP,
    S_DATA_WAIT, S_DATA_PID, S_DATA_BODY,
    S_HS_WAIT, S_HS_PID, S_HS_EOP,
    S_DONE, S_ERR, S_DRAIN
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          counting;
  logic          tok_cnt;
  logic [7:0]    dl_old, dl_new;
  logic [1:0]    dl_cnt;
  logic [2:0]    err_code;
  logic          push;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  // The drain timer runs regardless of bytes so a babbling sender cannot stall us.
  assign counting = (((state == S_DATA_WAIT) || (state == S_HS_WAIT)) && !byte_valid) ||
                    (state == S_DRAIN);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    next_state = state;
    err_code   = 3'd0;
    push       = 1'b0;
    if (byte_valid && eop && !(state inside {S_DONE, S_ERR, S_DRAIN})) begin
      next_state = S_ERR;
      err_code   = ERR_FRAME;
    end else begin
      case (state)
        S_IDLE: if (byte_valid) begin
          if (byte_data == SYNC_BYTE) next_state = S_TOK_PID;
          else begin next_state = S_ERR; err_code = ERR_SYNC; end
        end
        S_TOK_PID: if (byte_valid) begin
          if (byte_data == TOKEN_PID) next_state = S_TOK_BODY;
          else begin next_state = S_ERR; err_code = ERR_PID; end
        end else if (eop) begin next_state = S_ERR; err_code = ERR_FRAME; end
        S_TOK_BODY: if (byte_valid && tok_cnt) next_state = S_TOK_EOP;
          else if (eop) begin next_state = S_ERR; err_code = ERR_FRAME; end
        S_TOK_EOP: if (byte_valid) begin next_state = S_ERR; err_code = ERR_FRAME; end
          else if (eop) begin
            if (crc5_ok) next_state = S_DATA_WAIT;
            else begin next_state = S_ERR; err_code = ERR_CRC; end
          end
        S_DATA_WAIT, S_HS_WAIT: if (byte_valid) begin
          if (byte_data == SYNC_BYTE) next_state = (state == S_DATA_WAIT) ? S_DATA_PID : S_HS_PID;
          else begin next_state = S_ERR; err_code = ERR_SYNC; end
        end else if (tmo_hit) begin next_state = S_ERR; err_code = ERR_TIMEOUT; end
        S_DATA_PID: if (byte_valid) begin
          if ((byte_data == DATA0_PID && !data_toggle) || (byte_data == DATA1_PID && data_toggle))
            next_state = S_DATA_BODY;
          else if (byte_data == DATA0_PID || byte_data == DATA1_PID) begin
            next_state = S_ERR; err_code = ERR_TOGGLE;
          end else begin next_state = S_ERR; err_code = ERR_PID; end
        end else if (eop) begin next_state = S_ERR; err_code = ERR_FRAME; end
        S_DATA_BODY: if (byte_valid) begin
          if (dl_cnt == 2'd2) begin
            if (byte_count == MAX_CNT) begin next_state = S_ERR; err_code = ERR_FRAME; end
            else push = 1'b1;
          end
        end else if (eop) begin
          if (dl_cnt != 2'd2) begin next_state = S_ERR; err_code = ERR_FRAME; end
          else if (!crc16_ok) begin next_state = S_ERR; err_code = ERR_CRC; end
          else next_state = S_HS_WAIT;
        end
        S_HS_PID: if (byte_valid) begin
          if (byte_data == ACK_PID) next_state = S_HS_EOP;
          else begin next_state = S_ERR; err_code = ERR_PID; end
        end else if (eop) begin next_state = S_ERR; err_code = ERR_FRAME; end
        S_HS_EOP: if (byte_valid) begin next_state = S_ERR; err_code = ERR_FRAME; end
          else if (eop) next_state = S_DONE;
        S_DONE:  next_state = S_IDLE;
        S_ERR:   next_state = S_DRAIN;
        S_DRAIN: if (eop || tmo_hit) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      rcv_data_ready <= 1'b0;
      rcv_error      <= 1'b0;
      error_code     <= 3'd0;
      data_toggle    <= 1'b0;
      wr_en          <= 1'b0;
      wr_data        <= 8'd0;
      byte_count     <= '0;
      tmo_cnt        <= '0;
      tok_cnt        <= 1'b0;
      dl_old         <= 8'd0;
      dl_new         <= 8'd0;
      dl_cnt         <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      state          <= next_state;
      busy           <= (next_state != S_IDLE);
      rcv_data_ready <= (next_state == S_DONE);
      rcv_error      <= (next_state == S_ERR);
      wr_en          <= push;
      if (next_state == S_ERR) error_code <= err_code;

      if (clear_toggle)                data_toggle <= 1'b0;
      else if (next_state == S_DONE)   data_toggle <= ~data_toggle;

      if (next_state != state) begin
        tmo_cnt <= '0;
        tok_cnt <= 1'b0;
      end else begin
        if (counting) tmo_cnt <= tmo_cnt + TW'(1);
        if (state == S_TOK_BODY && byte_valid) tok_cnt <= 1'b1;
      end

      // Two-byte delay line: the newest two bytes are always the CRC16 candidates.
      if (next_state == S_DATA_PID && state != S_DATA_PID) begin
        byte_count <= '0;
        dl_cnt     <= 2'd0;
      end else if (push) begin
        wr_data    <= dl_old;
        byte_count <= byte_count + CW'(1);
        dl_old     <= dl_new;
        dl_new     <= byte_data;
      end else if (state == S_DATA_BODY && next_state == S_DATA_BODY && byte_valid) begin
        if (dl_cnt == 2'd0) dl_old <= byte_data;
        else                dl_new <= byte_data;
        dl_cnt <= dl_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_txn_ctrl.sv
// Scoreboard bench for usb_rx_txn_ctrl: a packet-level model predicts payload writes,
// completions and error codes; a negedge monitor compares whatever the DUT presents.
module tb_usb_rx_txn_ctrl;

  localparam int MAXB = 8;
  localparam int TMO  = 32;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [7:0] SYNC = 8'h80, TOKEN = 8'h96, D0 = 8'h3C, D1 = 8'hB4, ACK = 8'h2D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          eop = 1'b0;
  logic          crc5_ok = 1'b0;
  logic          crc16_ok = 1'b0;
  logic          clear_toggle = 1'b0;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [CW-1:0] byte_count;
  logic          rcv_data_ready;
  logic          rcv_error;
  logic [2:0]    error_code;
  logic          data_toggle;
  logic          busy;

  always #5 clk = ~clk;

  usb_rx_txn_ctrl #(
    .MAX_DATA_BYTES(MAXB), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC), .TOKEN_PID(TOKEN),
    .DATA0_PID(D0), .DATA1_PID(D1), .ACK_PID(ACK)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .eop(eop),
    .crc5_ok(crc5_ok), .crc16_ok(crc16_ok), .clear_toggle(clear_toggle),
    .wr_en(wr_en), .wr_data(wr_data), .byte_count(byte_count),
    .rcv_data_ready(rcv_data_ready), .rcv_error(rcv_error), .error_code(error_code),
    .data_toggle(data_toggle), .busy(busy)
  );

  typedef enum int {EV_WR, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    int         cnt;
    logic       tog;
    logic [2:0] code;
  } ev_t;

  typedef struct {
    bit         bad_sync;
    bit         crc5_ok;
    bit         data_timeout;
    logic [7:0] pid;
    int         n;
    bit         crc16_ok;
    bit         ack_ok;
    bit         clear_at_eop;
  } txn_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         failures = 0;
  logic       model_tog = 1'b0;
  int         model_cnt = 0;
  logic [7:0] pay [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [7:0] d, input int c, input logic [2:0] code);
    ev_t e;
    e.kind = k; e.data = d; e.cnt = c; e.tog = model_tog; e.code = code;
    exp_q.push_back(e);
  endtask

  // Packet-level prediction of one transaction; stage tells the driver where it aborts
  // (1 token, 2 data, 3 handshake reached).
  task automatic model_txn(input txn_t t, output int stage);
    stage = 3;
    if (t.bad_sync)          begin expect_ev(EV_ERR, 8'd0, model_cnt, 3'd1); stage = 1; end
    else if (!t.crc5_ok)     begin expect_ev(EV_ERR, 8'd0, model_cnt, 3'd4); stage = 1; end
    else if (t.data_timeout) begin expect_ev(EV_ERR, 8'd0, model_cnt, 3'd6); stage = 2; end
    else if (t.pid != D0 && t.pid != D1) begin
      model_cnt = 0; expect_ev(EV_ERR, 8'd0, 0, 3'd2); stage = 2;
    end else if (((t.pid == D1) ? 1'b1 : 1'b0) != model_tog) begin
      model_cnt = 0; expect_ev(EV_ERR, 8'd0, 0, 3'd3); stage = 2;
    end else begin
      model_cnt = 0;
      for (int i = 0; i < t.n && i < MAXB; i++) begin
        model_cnt = i + 1;
        expect_ev(EV_WR, pay[i], model_cnt, 3'd0);
      end
      if (t.n > MAXB)        begin expect_ev(EV_ERR, 8'd0, model_cnt, 3'd5); stage = 2; end
      else if (!t.crc16_ok)  begin expect_ev(EV_ERR, 8'd0, model_cnt, 3'd4); stage = 2; end
      else if (!t.ack_ok)    expect_ev(EV_ERR, 8'd0, model_cnt, 3'd2);
      else begin
        model_tog = t.clear_at_eop ? 1'b0 : ~model_tog;
        expect_ev(EV_DONE, 8'd0, model_cnt, 3'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) check("wr_unexpected", wr_en, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr_kind", EV_WR, mon_e.kind);
          check("wr_data", wr_data, mon_e.data);
          check("wr_count", byte_count, mon_e.cnt);
        end
      end
      if (rcv_data_ready) begin
        if (exp_q.size() == 0) check("ready_unexpected", rcv_data_ready, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("ready_kind", EV_DONE, mon_e.kind);
          check("ready_count", byte_count, mon_e.cnt);
          check("ready_toggle", data_toggle, mon_e.tog);
        end
      end
      if (rcv_error) begin
        if (exp_q.size() == 0) check("error_unexpected", rcv_error, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("error_kind", EV_ERR, mon_e.kind);
          check("error_code", error_code, mon_e.code);
          check("error_count", byte_count, mon_e.cnt);
          check("error_toggle", data_toggle, mon_e.tog);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int mx);
    repeat ($urandom_range(mx, 0)) tick;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    tick;
    byte_valid = 1'b0;
    gap(2);
  endtask

  task automatic send_eop(input logic c5, input logic c16, input logic clr);
    eop = 1'b1; crc5_ok = c5; crc16_ok = c16; clear_toggle = clr;
    tick;
    eop = 1'b0; clear_toggle = 1'b0;
    gap(2);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin tick; k++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic pulse_clear;
    clear_toggle = 1'b1;
    tick;
    clear_toggle = 1'b0;
    model_tog = 1'b0;
  endtask

  task automatic send_token(input logic [7:0] sync_b, input logic c5);
    send_byte(sync_b); send_byte(TOKEN);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    send_eop(c5, 1'b0, 1'b0);
  endtask

  task automatic run_txn(input txn_t t);
    int stage;
    model_txn(t, stage);
    send_token(t.bad_sync ? 8'h81 : SYNC, t.crc5_ok);
    if (stage > 1 && !t.data_timeout) begin
      gap(6);
      send_byte(SYNC); send_byte(t.pid);
      for (int i = 0; i < t.n; i++) send_byte(pay[i]);
      send_byte(8'($urandom)); send_byte(8'($urandom));
      send_eop(1'b0, t.crc16_ok, 1'b0);
      if (stage == 3) begin
        gap(6);
        send_byte(SYNC); send_byte(t.ack_ok ? ACK : 8'hA5);
        send_eop(1'b0, 1'b0, t.clear_at_eop && t.ack_ok);
      end
    end
    wait_idle(3 * TMO + 16);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] cur_pid();
    return model_tog ? D1 : D0;
  endfunction

  function automatic txn_t good_txn(input logic [7:0] pid, input int n);
    txn_t t;
    t.bad_sync = 1'b0; t.crc5_ok = 1'b1; t.data_timeout = 1'b0; t.pid = pid; t.n = n;
    t.crc16_ok = 1'b1; t.ack_ok = 1'b1; t.clear_at_eop = 1'b0;
    return t;
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_wr_data"}, wr_data, 0);
    check({pfx, "_byte_count"}, byte_count, 0);
    check({pfx, "_ready"}, rcv_data_ready, 0);
    check({pfx, "_error"}, rcv_error, 0);
    check({pfx, "_error_code"}, error_code, 0);
    check({pfx, "_toggle"}, data_toggle, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    repeat (3) tick;
    check_zero("reset");
    rst = 1'b0;
    tick;

    // Good transaction A1 B2 C3 with DATA0.
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    run_txn(good_txn(D0, 3));
    check("toggle_after_good", data_toggle, model_tog);

    // DATA0 while DATA1 expected, then clear and retry with DATA0.
    run_txn(good_txn(D0, 2));
    pulse_clear;
    check("toggle_cleared", data_toggle, model_tog);
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    run_txn(good_txn(D0, 3));

    // Zero-length payload and an overlong one.
    run_txn(good_txn(cur_pid(), 0));
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    run_txn(good_txn(cur_pid(), MAXB + 1));
    run_txn(good_txn(cur_pid(), MAXB));

    // CRC failures on data and token.
    t = good_txn(cur_pid(), 4); t.crc16_ok = 1'b0; run_txn(t);
    t = good_txn(cur_pid(), 4); t.crc5_ok = 1'b0;  run_txn(t);

    // No data packet arrives.
    t = good_txn(cur_pid(), 4); t.data_timeout = 1'b1; run_txn(t);
    check("busy_after_timeout", busy, 0);

    // Reset in the middle of a payload after two writes.
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    expect_ev(EV_WR, pay[0], 1, 3'd0);
    expect_ev(EV_WR, pay[1], 2, 3'd0);
    send_token(SYNC, 1'b1);
    send_byte(SYNC); send_byte(cur_pid());
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
    tick; tick;
    check("writes_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    exp_q.delete();
    model_tog = 1'b0; model_cnt = 0;
    tick;
    rst = 1'b0;
    tick;
    run_txn(good_txn(D0, 5));

    // Bring toggle to 0, then clear_toggle together with the handshake eop must win over inversion.
    run_txn(good_txn(cur_pid(), 2));
    t = good_txn(cur_pid(), 1); t.clear_at_eop = 1'b1; run_txn(t);
    check("clear_beats_done", data_toggle, model_tog);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(7, 0) == 0) pulse_clear;
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      t = good_txn(cur_pid(), $urandom_range(MAXB, 0));
      case ($urandom_range(19, 0))
        0:       t.bad_sync = 1'b1;
        1:       t.crc5_ok = 1'b0;
        2:       t.data_timeout = 1'b1;
        3:       t.pid = 8'h55;
        4:       t.pid = model_tog ? D0 : D1;
        5:       t.n = MAXB + 1;
        6, 7:    t.crc16_ok = 1'b0;
        8:       t.ack_ok = 1'b0;
        9, 10:   t.clear_at_eop = 1'b1;
        default: ;
      endcase
      run_txn(t);
      check("toggle_between", data_toggle, model_tog);
    end

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
